// File: rtl/capture_controller.sv
// Acquisition sequencer: drives a trigger hub's arm/reset and generates ring-buffer
// write strobes and addresses for pre-trigger and post-trigger capture.
module capture_controller #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrigger_len,
  input  logic [ADDR_WIDTH-1:0] posttrigger_len,
  input  logic                  sample_valid,
  input  logic [1:0]            trigger_state,
  output logic                  arm,
  output logic                  reset,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle,
    StPreFill,
    StArming,
    StWaitTrig,
    StPostFill,
    StRelease
  } state_e;

  state_e state_q, state_d;

  logic arm_q, arm_d;
  logic reset_q, reset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] trig_q, trig_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] post_q, post_d;
  logic [ADDR_WIDTH-1:0] count_inc;

  logic writing;
  logic pre_hit;
  logic post_hit;

  assign writing   = (state_q == StPreFill) || (state_q == StArming) ||
                     (state_q == StWaitTrig) || (state_q == StPostFill);
  assign wr_en     = sample_valid & writing;
  assign count_inc = count_q + ADDR_WIDTH'(1);

  // A fill is complete once the sample written this cycle brings the count to the
  // target, so exactly len samples are written inside the fill state.
  assign pre_hit  = (count_q == pre_q) || (wr_en && (count_inc == pre_q));
  assign post_hit = (count_q == post_q) || (wr_en && (count_inc == post_q));

  always_comb begin
    state_d   = state_q;
    addr_d    = wr_en ? addr_q + ADDR_WIDTH'(1) : addr_q;
    trig_d    = trig_q;
    count_d   = count_q;
    pre_d     = pre_q;
    post_d    = post_q;
    done_d    = done_q;
    aborted_d = aborted_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StPreFill;
          addr_d    = '0;
          done_d    = 1'b0;
          count_d   = '0;
          pre_d     = pretrigger_len;
          post_d    = posttrigger_len;
          aborted_d = 1'b0;
        end
      end
      StPreFill: begin
        // Saturate so a slow hub flush cannot push the count past the target.
        if (wr_en && (count_q != pre_q)) count_d = count_inc;
        if (pre_hit && (trigger_state == 2'd0)) state_d = StArming;
      end
      StArming: begin
        if (trigger_state == 2'd1) state_d = StWaitTrig;
      end
      StWaitTrig: begin
        if (trigger_state[1]) begin
          trig_d  = addr_q;
          count_d = '0;
          state_d = StPostFill;
        end
      end
      StPostFill: begin
        if (wr_en && (count_q != post_q)) count_d = count_inc;
        if (post_hit) state_d = StRelease;
      end
      StRelease: begin
        if (trigger_state == 2'd0) begin
          state_d = StIdle;
          done_d  = !aborted_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d   = StRelease;
      aborted_d = 1'b1;
      done_d    = done_q;
    end

    arm_d   = (state_d == StArming);
    reset_d = (state_d == StRelease) || ((state_d == StPreFill) && (trigger_state != 2'd0));
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      arm_q     <= 1'b0;
      reset_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      addr_q    <= '0;
      trig_q    <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      post_q    <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      reset_q   <= reset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      addr_q    <= addr_d;
      trig_q    <= trig_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
    end
  end

  assign arm          = arm_q;
  assign reset        = reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_addr      = addr_q;
  assign trigger_addr = trig_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: a per-cycle vector table for a normal run
// plus hand-written sequences for wrap, stale hub, sparse samples, abort and reset.
module tb_capture_controller;
  localparam int AW  = 10;
  localparam int AWS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, sample_valid;
  logic [1:0]    trigger_state;
  logic [AW-1:0] pre_len, post_len;

  logic          arm, reset, wr_en, busy, done;
  logic [AW-1:0] wr_addr, trigger_addr;

  logic           arm_w, reset_w, wr_en_w, busy_w, done_w;
  logic [AWS-1:0] wr_addr_w, trigger_addr_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  capture_controller #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .pretrigger_len (pre_len),
    .posttrigger_len(post_len),
    .sample_valid   (sample_valid),
    .trigger_state  (trigger_state),
    .arm            (arm),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .trigger_addr   (trigger_addr),
    .busy           (busy),
    .done           (done)
  );

  capture_controller #(.ADDR_WIDTH(AWS)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .pretrigger_len (pre_len[AWS-1:0]),
    .posttrigger_len(post_len[AWS-1:0]),
    .sample_valid   (sample_valid),
    .trigger_state  (trigger_state),
    .arm            (arm_w),
    .reset          (reset_w),
    .wr_en          (wr_en_w),
    .wr_addr        (wr_addr_w),
    .trigger_addr   (trigger_addr_w),
    .busy           (busy_w),
    .done           (done_w)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic       sv;
    logic [1:0] ts;
    logic       arm;
    logic       reset;
    logic       wr_en;
    logic       busy;
    logic       done;
    int         addr;
    int         taddr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: inputs change after the falling edge, outputs sampled 1ns later.
  task automatic drive(input logic s, input logic a, input logic v, input logic [1:0] t);
    @(negedge clk);
    start         = s;
    abort         = a;
    sample_valid  = v;
    trigger_state = t;
    #1;
  endtask

  task automatic setv(input int i, input logic s, input logic a, input logic v,
                      input logic [1:0] t, input logic ar, input logic rs, input logic we,
                      input logic bz, input logic dn, input int ad, input int ta);
    vecs[i] = '{s, a, v, t, ar, rs, we, bz, dn, ad, ta};
  endtask

  task automatic run_table(input string tag);
    pre_len  = 10'd4;
    post_len = 10'd3;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].start, vecs[i].abort, vecs[i].sv, vecs[i].ts);
      chk($sformatf("%s[%0d].arm", tag, i), arm, vecs[i].arm);
      chk($sformatf("%s[%0d].reset", tag, i), reset, vecs[i].reset);
      chk($sformatf("%s[%0d].wr_en", tag, i), wr_en, vecs[i].wr_en);
      chk($sformatf("%s[%0d].busy", tag, i), busy, vecs[i].busy);
      chk($sformatf("%s[%0d].done", tag, i), done, vecs[i].done);
      chk($sformatf("%s[%0d].wr_addr", tag, i), wr_addr, vecs[i].addr);
      chk($sformatf("%s[%0d].trigger_addr", tag, i), trigger_addr, vecs[i].taddr);
    end
  endtask

  initial begin
    //         st ab sv ts   arm rst we busy done addr taddr
    setv( 0,  1, 0, 1, 0,   0,  0,  0, 0,   0,   0,   0);
    setv( 1,  0, 0, 1, 0,   0,  0,  1, 1,   0,   0,   0);
    setv( 2,  0, 0, 1, 0,   0,  0,  1, 1,   0,   1,   0);
    setv( 3,  0, 0, 1, 0,   0,  0,  1, 1,   0,   2,   0);
    setv( 4,  0, 0, 1, 0,   0,  0,  1, 1,   0,   3,   0);
    setv( 5,  0, 0, 1, 0,   1,  0,  1, 1,   0,   4,   0);
    setv( 6,  0, 0, 1, 1,   1,  0,  1, 1,   0,   5,   0);
    setv( 7,  0, 0, 1, 1,   0,  0,  1, 1,   0,   6,   0);
    setv( 8,  1, 0, 1, 1,   0,  0,  1, 1,   0,   7,   0);
    setv( 9,  0, 0, 1, 1,   0,  0,  1, 1,   0,   8,   0);
    setv(10,  0, 0, 1, 1,   0,  0,  1, 1,   0,   9,   0);
    setv(11,  0, 0, 1, 2,   0,  0,  1, 1,   0,  10,   0);
    setv(12,  0, 0, 1, 2,   0,  0,  1, 1,   0,  11,  10);
    setv(13,  0, 0, 1, 2,   0,  0,  1, 1,   0,  12,  10);
    setv(14,  0, 0, 1, 2,   0,  0,  1, 1,   0,  13,  10);
    setv(15,  0, 0, 1, 2,   0,  1,  0, 1,   0,  14,  10);
    setv(16,  0, 0, 1, 0,   0,  1,  0, 1,   0,  14,  10);
    setv(17,  0, 0, 1, 0,   0,  0,  0, 0,   1,  14,  10);

    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    sample_valid  = 1'b0;
    trigger_state = 2'd0;
    pre_len       = '0;
    post_len      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.arm", arm, 0);
    chk("rst.reset", reset, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.trigger_addr", trigger_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_table("normal");

    // Wrap on the 3-bit instance: 2 pre, 1 arming, 10 waiting, then trigger at 13 mod 8.
    pre_len  = 10'd2;
    post_len = 10'd1;
    drive(1, 0, 1, 0);
    for (int i = 0; i < 14; i++) begin
      logic [1:0] t;
      t = (i < 2) ? 2'd0 : (i < 13) ? 2'd1 : 2'd2;
      drive(0, 0, 1, t);
      chk($sformatf("wrap[%0d].wr_en", i), wr_en_w, 1);
      chk($sformatf("wrap[%0d].wr_addr", i), wr_addr_w, i % 8);
    end
    drive(0, 0, 1, 2);
    chk("wrap.trigger_addr", trigger_addr_w, 5);
    chk("wrap.post_addr", wr_addr_w, 6);
    drive(0, 0, 1, 0);
    chk("wrap.release_reset", reset_w, 1);
    drive(0, 0, 0, 0);
    chk("wrap.done", done_w, 1);
    chk("wrap.final_addr", wr_addr_w, 7);

    // Stale hub: reset must be held and arm withheld until the hub reports disarmed.
    pre_len = 10'd1;
    drive(1, 0, 1, 3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 3);
      chk($sformatf("stale[%0d].reset", i), reset, 1);
      chk($sformatf("stale[%0d].arm", i), arm, 0);
    end
    drive(0, 0, 1, 0);
    chk("stale.last_reset", reset, 1);
    chk("stale.last_arm", arm, 0);
    drive(0, 0, 1, 0);
    chk("stale.arm", arm, 1);
    chk("stale.reset_drop", reset, 0);
    drive(0, 1, 1, 1);
    drive(0, 0, 1, 1);
    chk("stale.abort_reset", reset, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("stale.abort_done", done, 0);
    chk("stale.abort_busy", busy, 0);

    // Sparse samples: one valid sample every third cycle.
    pre_len  = 10'd2;
    post_len = 10'd2;
    drive(1, 0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      logic       v;
      logic [1:0] t;
      v = (i % 3 == 0);
      t = (i < 4) ? 2'd0 : (i < 6) ? 2'd1 : 2'd2;
      drive(0, 0, v, t);
      chk($sformatf("sparse[%0d].wr_en", i), wr_en, v);
      chk($sformatf("sparse[%0d].wr_addr", i), wr_addr, (i + 2) / 3);
      if (i == 4) chk("sparse.arm", arm, 1);
    end
    drive(0, 0, 1, 2);
    chk("sparse.release_wr_en", wr_en, 0);
    chk("sparse.release_reset", reset, 1);
    chk("sparse.trigger_addr", trigger_addr, 2);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("sparse.done", done, 1);
    chk("sparse.busy", busy, 0);

    // Abort from WAIT_TRIG; done was set by the previous run and must be cleared.
    pre_len  = 10'd0;
    post_len = 10'd3;
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    chk("abort.arm", arm, 1);
    drive(0, 0, 1, 1);
    chk("abort.wait_arm", arm, 0);
    drive(0, 1, 1, 1);
    drive(0, 0, 1, 1);
    chk("abort.reset", reset, 1);
    chk("abort.arm_low", arm, 0);
    chk("abort.wr_en", wr_en, 0);
    chk("abort.busy", busy, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("abort.done", done, 0);
    chk("abort.idle", busy, 0);
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    chk("start_abort.busy", busy, 0);
    chk("start_abort.wr_en", wr_en, 0);

    // Asynchronous reset in POST_FILL, then a fresh normal run.
    post_len = 10'd5;
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 2);
    drive(0, 0, 1, 2);
    chk("midrst.pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.arm", arm, 0);
    chk("midrst.reset", reset, 0);
    chk("midrst.wr_en", wr_en, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.wr_addr", wr_addr, 0);
    chk("midrst.trigger_addr", trigger_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_table("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
Acquisition sequencer that drives a trigger hub. It issues the arm and reset controls, consumes the hub's 2-bit trigger_state, and generates ring-buffer write strobes and addresses for pre-trigger and post-trigger sample capture. It sits between the host control registers and the sample memory of each MSO capture channel.

Parameters:
ADDR_WIDTH, 10, width of the capture RAM address; the ring wraps modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a capture run; sampled in IDLE only
abort  input  1  cancel the run in progress
pretrigger_len  input  ADDR_WIDTH  samples to write before arming
posttrigger_len  input  ADDR_WIDTH  samples to write after the trigger
sample_valid  input  1  one new sample is present this cycle
trigger_state  input  2  hub state: 0 disarmed, 1 armed, 2 triggered, 3 cleared
arm  output  1  arm request to the hub; level signal
reset  output  1  disarm request to the hub; level signal
wr_en  output  1  write the current sample at wr_addr
wr_addr  output  ADDR_WIDTH  ring write pointer
trigger_addr  output  ADDR_WIDTH  address of the first post-trigger sample
busy  output  1  high in every state except IDLE
done  output  1  sticky flag: the last run completed normally

Behaviour:
- Reset values: state=IDLE; arm=0, reset=0, wr_en=0, wr_addr=0, trigger_addr=0, busy=0, done=0. All counters are 0.
- States: IDLE, PRE_FILL, ARMING, WAIT_TRIG, POST_FILL, RELEASE. arm, reset, busy and the state register are registered. wr_en = sample_valid AND (state is PRE_FILL, ARMING, WAIT_TRIG or POST_FILL); it is combinational.
- Write rule: when wr_en=1, the sample is written at the current wr_addr, and wr_addr increments at the same edge, wrapping from 2^ADDR_WIDTH-1 to 0.
- IDLE: start=1 and abort=0 -> PRE_FILL. On that edge: wr_addr<=0, done<=0, count<=0, and pretrigger_len/posttrigger_len are latched. Later changes to the length inputs are ignored until the next start.
- PRE_FILL:
  - count increments on each wr_en.
  - reset=1 while trigger_state!=0, which flushes a stale hub.
  - Exit to ARMING when count==latched pre length AND trigger_state==0. A pre length of 0 therefore exits as soon as the hub is disarmed.
- ARMING: arm=1 and writes continue. Exit to WAIT_TRIG when trigger_state==1; arm drops on that edge.
- WAIT_TRIG: writes continue and wrap freely. When trigger_state is 2 or 3: trigger_addr<=wr_addr (the pre-increment value when wr_en=1 that cycle), count<=0, go to POST_FILL. The sample written in that same cycle is the first post-trigger sample.
- POST_FILL: count increments on each wr_en. When count==latched post length -> RELEASE. A post length of 0 leaves after 1 cycle with no extra writes beyond that cycle's sample.
- RELEASE: reset=1 and wr_en=0. When trigger_state==0: reset drops, done<=1 (normal path only), go to IDLE.
- abort=1 in any non-IDLE state -> RELEASE next edge, with done left at 0. In IDLE, abort overrides start.
- start while busy is ignored.
- Total written samples = pre + (samples during ARMING/WAIT_TRIG) + post. The ring retains the last 2^ADDR_WIDTH samples. The host reconstructs the pre-trigger window from trigger_addr backwards.
- Asserting rst_n mid-run returns all outputs to reset values immediately; the hub is reset by the same rst_n.

Test Plan:
- Normal run (pre=4, post=3, sample_valid=1 always, hub model arms 1 cycle after arm, trigger 5 cycles later) -> 4 PRE_FILL writes at addresses 0..3; arm high until trigger_state=1; trigger_addr=address written on the trigger cycle; 3 post writes; reset pulse until state=0; done=1, busy=0.
- Wrap: ADDR_WIDTH=3, pre=2, trigger after 10 WAIT_TRIG samples -> wr_addr wraps 7->0; trigger_addr=(2+1+10) mod 8 per exact cycle count; no write gaps.
- Stale hub: trigger_state=3 at start -> reset asserted in PRE_FILL until the model returns 0; arm is not raised before then.
- Sparse sample_valid (1 every 3 cycles), pre=2, post=2 -> counters advance only on valid samples; wr_en is never high without sample_valid.
- Abort during WAIT_TRIG -> next cycle RELEASE, reset=1, arm=0; after hub returns 0, IDLE with done=0. Start and abort together in IDLE -> stays IDLE.
- rst_n low during POST_FILL -> all outputs zero asynchronously; after release, a fresh start performs a normal run.
